// File: rtl/pcie_tlp_regs.sv
// pcie_tlp_regs
// -------------
// Completer for host MMIO traffic on the pcie_x1 core's 16-bit VC0 TLP ports.
// It decodes 1-DW MRd32/MWr32 requests that hit BAR0. Writes land in a small
// register file that drives the LEDs. Reads are answered with a CplD.
//
// Register map (address bits [3:2]):
//   0 = LED (bits 7:0, zero-extended on read)
//   1 = scratch (32 bits)
//   2 = ID_VALUE (read-only)
//   3 = reads 0
//
// Optional feature macro: PCIE_TLP_REGS_UR_EN
//   defined   : ur_np / ur_p pulse for one cycle on unsupported requests
//   undefined : ur_np / ur_p tied low, unsupported requests dropped silently
//
// Ports:
//   clk, rstn                 125 MHz core clock, async active-low reset
//   rx_data/rx_st/rx_end      receive TLP words, MS header word first
//   rx_bar_hit                BAR hit, valid with rx_st (bit 0 = BAR0)
//   tx_req/tx_rdy             transmit request / grant
//   tx_data/tx_st/tx_end      transmit TLP words
//   bus_num/dev_num/func_num  completer ID
//   led                       LED register
//   ur_np/ur_p                unsupported non-posted / posted pulses
//   drop_cnt                  MRd dropped while the completion slot was busy (saturating)
//   rx_state_dbg/tx_state_dbg FSM state observation
//
// Handshake: tx_req rises when a completion is pending and holds until tx_rdy
// is sampled high. The TLP then goes out on the next 8 consecutive cycles,
// with tx_st on the first word and tx_end on the last. No back-pressure is
// applied once sending has started.

module pcie_tlp_regs #(
    parameter logic [31:0] ID_VALUE  = 32'h5749_4747,
    parameter logic [7:0]  LED_RESET = 8'hFE
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] rx_data,
    input  logic        rx_st,
    input  logic        rx_end,
    input  logic [6:0]  rx_bar_hit,
    output logic        tx_req,
    input  logic        tx_rdy,
    output logic [15:0] tx_data,
    output logic        tx_st,
    output logic        tx_end,
    input  logic [7:0]  bus_num,
    input  logic [4:0]  dev_num,
    input  logic [2:0]  func_num,
    output logic [7:0]  led,
    output logic        ur_np,
    output logic        ur_p,
    output logic [7:0]  drop_cnt,
    output logic [1:0]  rx_state_dbg,
    output logic [1:0]  tx_state_dbg
);

    localparam logic [1:0] RX_IDLE = 2'd0;
    localparam logic [1:0] RX_HDR  = 2'd1;
    localparam logic [1:0] RX_DATA = 2'd2;
    localparam logic [1:0] RX_DEC  = 2'd3;

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_REQ  = 2'd1;
    localparam logic [1:0] TX_SEND = 2'd2;

    logic [1:0]  rx_state, tx_state;
    logic [2:0]  rx_idx;
    logic        bar0_q;
    logic [7:0]  fmt_type;
    logic [9:0]  len;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [3:0]  fbe;
    logic [4:0]  addr_lo;      // address bits [6:2]
    logic [15:0] dw_hi, dw_lo; // data words 6 and 7
    logic        end5;         // rx_end landed on word 5

    logic [7:0]  led_q;
    logic [31:0] scratch;

    logic        slot_full;
    logic [15:0] slot_rid;
    logic [7:0]  slot_tag;
    logic [4:0]  slot_addr;
    logic [31:0] slot_data;
    logic [3:0]  tx_cnt;
    logic [15:0] cpl_w [8];

    logic        in_dec, hdr_mrd, hdr_mwr, rd_hit, wr_hit;
    logic [31:0] wdata, rd_data;
    logic        unused_bar_bits;

    assign unused_bar_bits = ^rx_bar_hit[6:1];

    // ---------------- receive capture ----------------
    // A fmt[1]=1 request must end on word 7; anything else that ends on
    // word 5 or 7 reaches RX_DEC and is classified there. Early or missing
    // rx_end drops the TLP here without reaching RX_DEC.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_state <= RX_IDLE;
            rx_idx   <= 3'd0;
            bar0_q   <= 1'b0;
            fmt_type <= 8'h00;
            len      <= 10'd0;
            req_id   <= 16'h0000;
            tag      <= 8'h00;
            fbe      <= 4'h0;
            addr_lo  <= 5'd0;
            dw_hi    <= 16'h0000;
            dw_lo    <= 16'h0000;
            end5     <= 1'b0;
        end else if (rx_st) begin
            fmt_type <= rx_data[15:8];
            bar0_q   <= rx_bar_hit[0];
            rx_idx   <= 3'd1;
            rx_state <= rx_end ? RX_IDLE : RX_HDR;
        end else begin
            case (rx_state)
                RX_HDR: begin
                    case (rx_idx)
                        3'd1: len <= rx_data[9:0];
                        3'd2: req_id <= rx_data;
                        3'd3: begin
                            tag <= rx_data[15:8];
                            fbe <= rx_data[3:0];
                        end
                        3'd5: addr_lo <= rx_data[6:2];
                        default: ;
                    endcase
                    rx_idx <= rx_idx + 3'd1;
                    if (rx_idx == 3'd5) begin
                        end5 <= rx_end;
                        if (rx_end) rx_state <= fmt_type[6] ? RX_IDLE : RX_DEC;
                        else        rx_state <= RX_DATA;
                    end else if (rx_end) begin
                        rx_state <= RX_IDLE;
                    end
                end
                RX_DATA: begin
                    if (rx_idx == 3'd6) begin
                        dw_hi  <= rx_data;
                        rx_idx <= 3'd7;
                        if (rx_end) rx_state <= RX_IDLE;
                    end else begin
                        dw_lo    <= rx_data;
                        rx_state <= rx_end ? RX_DEC : RX_IDLE;
                    end
                end
                RX_DEC:  rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // ---------------- decode ----------------
    always_comb begin
        in_dec  = (rx_state == RX_DEC);
        hdr_mrd = (fmt_type == 8'h00) && (len == 10'd1) && end5;
        hdr_mwr = (fmt_type == 8'h40) && (len == 10'd1) && !end5;
        rd_hit  = in_dec && bar0_q && hdr_mrd;
        wr_hit  = in_dec && bar0_q && hdr_mwr;
        wdata   = {dw_lo[7:0], dw_lo[15:8], dw_hi[7:0], dw_hi[15:8]};
        case (addr_lo[1:0])
            2'd0:    rd_data = {24'h0, led_q};
            2'd1:    rd_data = scratch;
            2'd2:    rd_data = ID_VALUE;
            default: rd_data = 32'h0;
        endcase
    end

`ifdef PCIE_TLP_REGS_UR_EN
    logic unsup;
    assign unsup = in_dec && !(rd_hit || wr_hit);
    assign ur_p  = unsup && fmt_type[6];
    assign ur_np = unsup && !fmt_type[6];
`else
    assign ur_p  = 1'b0;
    assign ur_np = 1'b0;
`endif

    // ---------------- register file ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            led_q   <= LED_RESET;
            scratch <= 32'h0;
        end else if (wr_hit) begin
            case (addr_lo[1:0])
                2'd0: if (fbe[0]) led_q <= wdata[7:0];
                2'd1: begin
                    for (int b = 0; b < 4; b++)
                        if (fbe[b]) scratch[8*b +: 8] <= wdata[8*b +: 8];
                end
                default: ;
            endcase
        end
    end

    // ---------------- completion slot and transmit ----------------
    always_comb begin
        cpl_w[0] = 16'h4A00;
        cpl_w[1] = 16'h0001;
        cpl_w[2] = {bus_num, dev_num, func_num};
        cpl_w[3] = 16'h0004;
        cpl_w[4] = slot_rid;
        cpl_w[5] = {slot_tag, 1'b0, slot_addr, 2'b00};
        cpl_w[6] = {slot_data[7:0], slot_data[15:8]};
        cpl_w[7] = {slot_data[23:16], slot_data[31:24]};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_full <= 1'b0;
            slot_rid  <= 16'h0;
            slot_tag  <= 8'h0;
            slot_addr <= 5'd0;
            slot_data <= 32'h0;
            drop_cnt  <= 8'h00;
            tx_state  <= TX_IDLE;
            tx_cnt    <= 4'd0;
            tx_req    <= 1'b0;
            tx_st     <= 1'b0;
            tx_end    <= 1'b0;
            tx_data   <= 16'h0;
        end else begin
            // Read data is sampled here, before any same-cycle write lands.
            if (rd_hit) begin
                if (slot_full) begin
                    if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                end else begin
                    slot_full <= 1'b1;
                    slot_rid  <= req_id;
                    slot_tag  <= tag;
                    slot_addr <= addr_lo;
                    slot_data <= rd_data;
                end
            end
            case (tx_state)
                TX_IDLE: begin
                    if (rd_hit && !slot_full) begin
                        tx_state <= TX_REQ;
                        tx_req   <= 1'b1;
                    end
                end
                TX_REQ: begin
                    if (tx_rdy) begin
                        tx_req   <= 1'b0;
                        tx_st    <= 1'b1;
                        tx_data  <= cpl_w[0];
                        tx_cnt   <= 4'd1;
                        tx_state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    tx_st <= 1'b0;
                    if (tx_cnt == 4'd8) begin
                        tx_data   <= 16'h0;
                        tx_end    <= 1'b0;
                        slot_full <= 1'b0;
                        tx_state  <= TX_IDLE;
                    end else begin
                        tx_data <= cpl_w[tx_cnt[2:0]];
                        tx_end  <= (tx_cnt == 4'd7);
                        tx_cnt  <= tx_cnt + 4'd1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    assign led          = led_q;
    assign rx_state_dbg = rx_state;
    assign tx_state_dbg = tx_state;

endmodule

// File: tb/tb_pcie_tlp_regs.sv
// Testbench for pcie_tlp_regs: directed test-plan sequences, a table of
// register write/read vectors, a table of unsupported/malformed TLPs, a
// randomized phase against a register-map model, and a reset mid-completion.

module tb_pcie_tlp_regs;

    localparam logic [31:0] ID_VALUE = 32'h5749_4747;
`ifdef PCIE_TLP_REGS_UR_EN
    localparam int UR_ON = 1;
`else
    localparam int UR_ON = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    always #4 clk = ~clk;

    logic [15:0] rx_data, tx_data;
    logic        rx_st, rx_end, tx_req, tx_rdy, tx_st, tx_end, ur_np, ur_p;
    logic [6:0]  rx_bar_hit;
    logic [7:0]  bus_num, led, drop_cnt;
    logic [4:0]  dev_num;
    logic [2:0]  func_num;
    logic [1:0]  rx_state_dbg, tx_state_dbg;

    pcie_tlp_regs dut (
        .clk(clk), .rstn(rstn),
        .rx_data(rx_data), .rx_st(rx_st), .rx_end(rx_end), .rx_bar_hit(rx_bar_hit),
        .tx_req(tx_req), .tx_rdy(tx_rdy), .tx_data(tx_data), .tx_st(tx_st), .tx_end(tx_end),
        .bus_num(bus_num), .dev_num(dev_num), .func_num(func_num),
        .led(led), .ur_np(ur_np), .ur_p(ur_p), .drop_cnt(drop_cnt),
        .rx_state_dbg(rx_state_dbg), .tx_state_dbg(tx_state_dbg)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / model ----------------
    int pass_cnt = 0;
    int total_cnt = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  m_led;
    logic [31:0] m_scratch;
    logic [15:0] tw [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] m_read(input logic [15:0] addr);
        case (addr[3:2])
            2'd0:    return {24'h0, m_led};
            2'd1:    return m_scratch;
            2'd2:    return ID_VALUE;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_write(input logic [15:0] addr, input logic [3:0] be, input logic [31:0] data);
        if (addr[3:2] == 2'd0 && be[0]) m_led = data[7:0];
        if (addr[3:2] == 2'd1)
            for (int b = 0; b < 4; b++)
                if (be[b]) m_scratch[8*b +: 8] = data[8*b +: 8];
    endtask

    task automatic push_cpl(input logic [15:0] rid, input logic [7:0] tag,
                            input logic [15:0] addr, input logic [31:0] data);
        exp_q.push_back(16'h4A00);
        exp_q.push_back(16'h0001);
        exp_q.push_back({bus_num, dev_num, func_num});
        exp_q.push_back(16'h0004);
        exp_q.push_back(rid);
        exp_q.push_back({tag, 1'b0, addr[6:2], 2'b00});
        exp_q.push_back({data[7:0], data[15:8]});
        exp_q.push_back({data[23:16], data[31:24]});
    endtask

    // ---------------- drivers ----------------
    task automatic build(input logic [2:0] fmt, input logic [4:0] typ, input logic [9:0] len,
                         input logic [15:0] rid, input logic [7:0] tag, input logic [3:0] be,
                         input logic [15:0] addr, input logic [31:0] data);
        tw[0] = {fmt, typ, 8'h00};
        tw[1] = {6'b0, len};
        tw[2] = rid;
        tw[3] = {tag, 4'h0, be};
        tw[4] = 16'h0000;
        tw[5] = {addr[15:2], 2'b00};
        tw[6] = {data[7:0], data[15:8]};
        tw[7] = {data[23:16], data[31:24]};
    endtask

    // Returns #1 after the edge that sampled the last word (the decode cycle).
    task automatic send_tlp(input int nwords, input int end_at, input logic [6:0] bar);
        for (int i = 0; i < nwords; i++) begin
            @(posedge clk); #1;
            rx_data    = tw[i];
            rx_st      = (i == 0);
            rx_end     = (i == end_at);
            rx_bar_hit = (i == 0) ? bar : 7'h00;
        end
        @(posedge clk); #1;
        rx_data = 16'h0; rx_st = 1'b0; rx_end = 1'b0; rx_bar_hit = 7'h00;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [3:0] be, input logic [31:0] data);
        build(3'b010, 5'd0, 10'd1, 16'h0000, 8'h00, be, addr, data);
        send_tlp(8, 7, 7'h01);
        m_write(addr, be, data);
        @(posedge clk); #1;
    endtask

    task automatic collect_cpl(input int delay);
        int k;
        logic [7:0]  st_bits, end_bits;
        logic [15:0] exp_w;
        k = 0;
        while (!tx_req && k < 32) begin
            @(negedge clk);
            k++;
        end
        check("tx_req_seen", tx_req, 1);
        if (!tx_req) begin
            exp_q.delete();
            return;
        end
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            check("tx_req_hold", tx_req, 1);
        end
        tx_rdy = 1'b1;
        @(posedge clk); #1;
        tx_rdy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
            check($sformatf("cpl_w%0d", i), tx_data, exp_w);
            st_bits[i]  = tx_st;
            end_bits[i] = tx_end;
        end
        check("cpl_tx_st_frame", st_bits, 8'h01);
        check("cpl_tx_end_frame", end_bits, 8'h80);
        @(negedge clk);
        check("tx_idle_after_cpl", {tx_req, tx_st, tx_end}, 0);
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [15:0] rid, input logic [7:0] tag,
                           input int delay);
        build(3'b000, 5'd0, 10'd1, rid, tag, 4'hF, addr, 32'h0);
        send_tlp(6, 5, 7'h01);
        push_cpl(rid, tag, addr, m_read(addr));
        collect_cpl(delay);
    endtask

    // ---------------- vector tables ----------------
    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [31:0] exp_rd;
    } reg_vec_t;

    typedef struct {
        logic [2:0] fmt;
        logic [4:0] typ;
        logic [9:0] len;
        logic [6:0] bar;
        int         nwords;
        int         end_at;
        int         exp_np;
        int         exp_p;
    } ur_vec_t;

    reg_vec_t rv [12];
    ur_vec_t  uv [9];

    initial begin
        int np_n, p_n, tx_seen, saw;
        logic [15:0] addr;
        logic [3:0]  be;
        logic [31:0] data;

        rv[0]  = '{1'b1, 16'h0004, 4'h3, 32'hDEADBEEF, 32'h0};
        rv[1]  = '{1'b0, 16'h0004, 4'h0, 32'h0,        32'h0000BEEF};
        rv[2]  = '{1'b1, 16'h0004, 4'hC, 32'h11223344, 32'h0};
        rv[3]  = '{1'b0, 16'h0004, 4'h0, 32'h0,        32'h1122BEEF};
        rv[4]  = '{1'b1, 16'h0008, 4'hF, 32'h00000000, 32'h0};
        rv[5]  = '{1'b0, 16'h0008, 4'h0, 32'h0,        32'h57494747};
        rv[6]  = '{1'b1, 16'h000C, 4'hF, 32'hFFFFFFFF, 32'h0};
        rv[7]  = '{1'b0, 16'h000C, 4'h0, 32'h0,        32'h00000000};
        rv[8]  = '{1'b1, 16'h0000, 4'hE, 32'h000000AA, 32'h0};
        rv[9]  = '{1'b0, 16'h0000, 4'h0, 32'h0,        32'h00000055};
        rv[10] = '{1'b1, 16'h0000, 4'h1, 32'hFFFFFF3C, 32'h0};
        rv[11] = '{1'b0, 16'h0070, 4'h0, 32'h0,        32'h0000003C};

        uv[0] = '{3'b000, 5'd0, 10'd1, 7'h02, 6, 5,  1, 0}; // MRd, no BAR0
        uv[1] = '{3'b010, 5'd0, 10'd1, 7'h02, 8, 7,  0, 1}; // MWr, no BAR0
        uv[2] = '{3'b000, 5'd0, 10'd2, 7'h01, 6, 5,  1, 0}; // MRd length 2
        uv[3] = '{3'b010, 5'd1, 10'd1, 7'h01, 8, 7,  0, 1}; // posted, wrong type
        uv[4] = '{3'b001, 5'd0, 10'd1, 7'h01, 8, 7,  1, 0}; // 4DW MRd
        uv[5] = '{3'b000, 5'd0, 10'd1, 7'h01, 4, 3,  0, 0}; // MRd ends early
        uv[6] = '{3'b010, 5'd0, 10'd1, 7'h01, 6, 5,  0, 0}; // MWr ends early
        uv[7] = '{3'b010, 5'd0, 10'd1, 7'h01, 7, 6,  0, 0}; // MWr ends on word 6
        uv[8] = '{3'b010, 5'd0, 10'd1, 7'h01, 8, -1, 0, 0}; // MWr, no rx_end

        rstn = 1'b0; rx_data = 16'h0; rx_st = 1'b0; rx_end = 1'b0; rx_bar_hit = 7'h0;
        tx_rdy = 1'b0; bus_num = 8'h01; dev_num = 5'd0; func_num = 3'd0;
        m_led = 8'hFE; m_scratch = 32'h0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("rst_led", led, 8'hFE);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_tx_strobes", {tx_req, tx_st, tx_end}, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_ur", {ur_np, ur_p}, 0);
        check("rst_fsm_states", {rx_state_dbg, tx_state_dbg}, 0);

        // ---- MWr LED = 0x55 ----
        build(3'b010, 5'd0, 10'd1, 16'h0000, 8'h00, 4'h1, 16'h0000, 32'h00000055);
        send_tlp(8, 7, 7'h01);
        m_write(16'h0000, 4'h1, 32'h00000055);
        @(posedge clk); #1;
        check("mwr_led_55", led, 8'h55);
        saw = 0;
        repeat (4) begin @(negedge clk); saw |= int'(tx_req | tx_st); end
        check("mwr_no_tx", saw, 0);

        // ---- MRd ID register, exact completion and tx_req timing ----
        build(3'b000, 5'd0, 10'd1, 16'h0100, 8'h07, 4'hF, 16'h0008, 32'h0);
        send_tlp(6, 5, 7'h01);
        @(negedge clk);
        check("tx_req_low_in_dec", tx_req, 0);
        @(negedge clk);
        check("tx_req_2_after_end", tx_req, 1);
        exp_q.push_back(16'h4A00); exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0100); exp_q.push_back(16'h0004);
        exp_q.push_back(16'h0100); exp_q.push_back(16'h0708);
        exp_q.push_back({ID_VALUE[7:0], ID_VALUE[15:8]});
        exp_q.push_back({ID_VALUE[23:16], ID_VALUE[31:24]});
        collect_cpl(2);

        // ---- register vector table ----
        for (int i = 0; i < 12; i++) begin
            if (rv[i].wr) begin
                do_write(rv[i].addr, rv[i].be, rv[i].data);
            end else begin
                build(3'b000, 5'd0, 10'd1, 16'h0200 + 16'(i), 8'(8'h10 + i), 4'hF, rv[i].addr, 32'h0);
                send_tlp(6, 5, 7'h01);
                push_cpl(16'h0200 + 16'(i), 8'(8'h10 + i), rv[i].addr, rv[i].exp_rd);
                collect_cpl(i % 3);
            end
        end
        check("led_after_table", led, m_led);

        // ---- two back-to-back MRd with tx_rdy low: second dropped ----
        build(3'b000, 5'd0, 10'd1, 16'h0300, 8'h21, 4'hF, 16'h0004, 32'h0);
        send_tlp(6, 5, 7'h01);
        push_cpl(16'h0300, 8'h21, 16'h0004, m_read(16'h0004));
        build(3'b000, 5'd0, 10'd1, 16'h0301, 8'h22, 4'hF, 16'h0000, 32'h0);
        send_tlp(6, 5, 7'h01);
        @(posedge clk); #1;
        check("drop_cnt_one", drop_cnt, 1);
        check("tx_req_still_first", tx_req, 1);
        collect_cpl(1);
        saw = 0;
        repeat (6) begin @(negedge clk); saw |= int'(tx_req | tx_st); end
        check("no_cpl_for_dropped", saw, 0);

        // ---- unsupported and malformed TLPs ----
        for (int i = 0; i < 9; i++) begin
            build(uv[i].fmt, uv[i].typ, uv[i].len, 16'h0400, 8'h30, 4'h1, 16'h0000, 32'h00000099);
            send_tlp(uv[i].nwords, uv[i].end_at, uv[i].bar);
            np_n = 0; p_n = 0; tx_seen = 0;
            repeat (4) begin
                @(negedge clk);
                np_n += int'(ur_np);
                p_n  += int'(ur_p);
                tx_seen |= int'(tx_req);
            end
            check($sformatf("ur_np_count[%0d]", i), np_n, uv[i].exp_np * UR_ON);
            check($sformatf("ur_p_count[%0d]", i), p_n, uv[i].exp_p * UR_ON);
            check($sformatf("bad_tlp_no_tx[%0d]", i), tx_seen, 0);
            check($sformatf("bad_tlp_led[%0d]", i), led, m_led);
        end

        // ---- randomized traffic against the register-map model ----
        for (int n = 0; n < 40; n++) begin
            addr = 16'($urandom_range(0, 31) * 4);
            if ($urandom_range(0, 1) == 1) begin
                be   = 4'($urandom_range(0, 15));
                data = $urandom;
                do_write(addr, be, data);
                check("rand_led", led, m_led);
            end else begin
                do_read(addr, 16'($urandom), 8'($urandom), $urandom_range(0, 3));
            end
        end
        check("rand_drop_cnt", drop_cnt, 1);

        // ---- reset in the middle of a completion ----
        build(3'b000, 5'd0, 10'd1, 16'h0500, 8'h40, 4'hF, 16'h0004, 32'h0);
        send_tlp(6, 5, 7'h01);
        saw = 0;
        while (!tx_req && saw < 32) begin @(negedge clk); saw++; end
        check("rst_mid_tx_req", tx_req, 1);
        tx_rdy = 1'b1;
        @(posedge clk); #1;
        tx_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rst_mid_strobes", {tx_req, tx_st, tx_end}, 0);
        check("rst_mid_tx_data", tx_data, 0);
        check("rst_mid_led", led, 8'hFE);
        check("rst_mid_fsm", {rx_state_dbg, tx_state_dbg}, 0);
        m_led = 8'hFE; m_scratch = 32'h0;
        @(posedge clk); #1;
        rstn = 1'b1;
        check("rst_mid_drop_cnt", drop_cnt, 0);
        do_read(16'h0004, 16'h0600, 8'h41, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
